pipe_stage_reg: RTL and testbench

- Generic, parametrised successor to the fixed ID/EX-style stage register.
- Carries a data bundle and a control bundle through DEPTH register stages, each with a valid bit.
- Supports stall (freeze all stages) and flush (convert all stages to bubbles), and zeroes control on bubbles so downstream logic sees a NOP.
- Includes a saturating bubble counter for performance debug; instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_stage_cell.sv | 47 ++++
 rtl/pipe_stage_reg.sv | 81 ++++++++
 tb/tb_pipe_stage_reg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, control-field layout and NOP encoding for pipeline stage registers.
// No logic; constants only.
// Default widths match the ID/EX boundary.
package pipe_pkg;

    localparam int DATA_W_ID_EX = 111;
    localparam int CTRL_W_ID_EX = 12;

    // Bit positions of the decoded control fields inside the ctrl bundle
    localparam int CTRL_ALUSRC_BIT   = 11;
    localparam int CTRL_MEMWRITE_BIT = 10;
    localparam int CTRL_MEMREAD_BIT  = 9;
    localparam int CTRL_REGWRITE_BIT = 8;
    localparam int CTRL_ALUOP_HI     = 7;
    localparam int CTRL_ALUOP_LO     = 4;
    localparam int CTRL_MEMTOREG_HI  = 3;
    localparam int CTRL_MEMTOREG_LO  = 2;
    localparam int CTRL_REGDST_HI    = 1;
    localparam int CTRL_REGDST_LO    = 0;

    // A bubble carries all-zero control so nothing downstream writes state
    localparam logic [CTRL_W_ID_EX-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: valid, ctrl and data registers with stall/flush and ctrl gating.
// Latency: 1 cycle from inputs to registered outputs.
// Backpressure: stall freezes the cell; flush (higher priority) turns it into a bubble.
module pipe_stage_cell
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_ID_EX,
    parameter int CTRL_W = CTRL_W_ID_EX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              vld_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              vld_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Flush beats stall; ctrl is forced to NOP whenever the captured slot is a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
        end else if (flush_i) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
        end else if (!stall_i) begin
            vld_q  <= vld_i;
            ctrl_q <= vld_i ? ctrl_i : '0;
            data_q <= data_i;
        end
    end

    assign vld_o  = vld_q;
    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: DEPTH cells of valid/ctrl/data plus a bubble counter.
// Latency: DEPTH cycles capture-to-output, +1 per stall cycle; outputs come straight from registers.
// Backpressure: stall holds every stage, flush empties every stage; the counter ignores both.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_ID_EX,
    parameter int CTRL_W = CTRL_W_ID_EX,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_count
);

    // Entry k feeds stage k; entry DEPTH is the last stage's output
    logic [DEPTH:0]    v_chain;
    logic [CTRL_W-1:0] c_chain [DEPTH+1];
    logic [DATA_W-1:0] d_chain [DEPTH+1];

    assign v_chain[0] = in_valid;
    assign c_chain[0] = in_ctrl;
    assign d_chain[0] = in_data;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage_cell #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .stall_i (stall),
            .flush_i (flush),
            .vld_i   (v_chain[k]),
            .ctrl_i  (c_chain[k]),
            .data_i  (d_chain[k]),
            .vld_o   (v_chain[k+1]),
            .ctrl_o  (c_chain[k+1]),
            .data_o  (d_chain[k+1])
        );
    end

    assign out_valid = v_chain[DEPTH];
    assign out_ctrl  = c_chain[DEPTH];
    assign out_data  = d_chain[DEPTH];

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins; otherwise count empty output cycles and stick at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (!out_valid && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register, cleared asynchronously with the stages
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_count = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a DEPTH=1/CNT_W=16 and a DEPTH=3/CNT_W=4 instance share one stimulus stream.
// Inputs change 2 time units after each rising edge; outputs are sampled there too.
// Ctrl-zero-on-bubble is checked on both instances at every falling edge.
module tb_pipe_stage_reg;

    localparam int DW = 111;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          stall;
    logic          flush;
    logic          cnt_clr;

    logic          a_valid, b_valid;
    logic [CW-1:0] a_ctrl, b_ctrl;
    logic [DW-1:0] a_data, b_data;
    logic [15:0]   a_cnt;
    logic [3:0]    b_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(1), .CNT_W(16)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(a_valid), .out_ctrl(a_ctrl), .out_data(a_data), .bubble_count(a_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(3), .CNT_W(4)) u_d3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(b_valid), .out_ctrl(b_ctrl), .out_data(b_data), .bubble_count(b_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] item_ctrl(input int i);
        return (i == 0) ? 12'h000 : (12'h100 + 12'(i));
    endfunction

    function automatic logic [DW-1:0] item_data(input int i);
        logic [DW-1:0] r;
        r = '0;
        if (i != 0) begin
            r[7:0]     = 8'(i);
            r[110:103] = 8'(i);
            r[60:53]   = 8'hA0 | 8'(i);
        end
        return r;
    endfunction

    task automatic drive_item(input int i);
        in_valid = (i != 0);
        in_ctrl  = item_ctrl(i);
        in_data  = item_data(i);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("inv_d1", a_valid ? 128'h0 : 128'(a_ctrl), 128'h0);
            chk("inv_d3", b_valid ? 128'h0 : 128'(b_ctrl), 128'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Stream table for the stall scenario: input item, stall, expected item at d3 output
    int t2_in  [8] = '{1, 2, 3, 3, 3, 0, 0, 0};
    int t2_stl [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
    int t2_exp [8] = '{0, 0, 0, 0, 1, 2, 3, 0};

    initial begin
        logic [DW-1:0] d1_vec;
        logic [DW-1:0] bub_dat;
        int            exp_cnt;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_ctrl  = '0;
        in_data  = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        cnt_clr  = 1'b0;
        #2;
        chk("rst_valid_d1", 128'(a_valid), 128'h0);
        chk("rst_ctrl_d3",  128'(b_ctrl),  128'h0);
        chk("rst_data_d3",  128'(b_data),  128'h0);
        chk("rst_cnt_d1",   128'(a_cnt),   128'h0);
        #1;
        reset = 1'b0;

        // Single-stage capture
        d1_vec   = {32'hA5A5A5A5, 32'h12345678, 32'hFFFF0000, 5'd1, 5'd2, 5'd3};
        in_valid = 1'b1;
        in_ctrl  = 12'h8D9;
        in_data  = d1_vec;
        edge_step();
        chk("t1_valid", 128'(a_valid), 128'h1);
        chk("t1_ctrl",  128'(a_ctrl),  128'h8D9);
        chk("t1_data",  128'(a_data),  128'(d1_vec));

        // Empty both pipes
        drive_item(0);
        flush = 1'b1;
        edge_step();
        flush = 1'b0;
        chk("flush_valid_d1", 128'(a_valid), 128'h0);
        chk("flush_data_d1",  128'(a_data),  128'h0);
        chk("flush_valid_d3", 128'(b_valid), 128'h0);

        // Stream with a two-cycle stall in the middle
        for (int e = 0; e < 8; e++) begin
            drive_item(t2_in[e]);
            stall = t2_stl[e][0];
            edge_step();
            chk($sformatf("t2_valid_e%0d", e + 1), 128'(b_valid), 128'(t2_exp[e] != 0));
            chk($sformatf("t2_ctrl_e%0d",  e + 1), 128'(b_ctrl),  128'(item_ctrl(t2_exp[e])));
            chk($sformatf("t2_data_e%0d",  e + 1), 128'(b_data),  128'(item_data(t2_exp[e])));
        end
        stall = 1'b0;

        // Fill with 4,5,6 then stall+flush together
        for (int i = 4; i <= 6; i++) begin
            drive_item(i);
            edge_step();
        end
        chk("t3_full_ctrl", 128'(b_ctrl), 128'(item_ctrl(4)));
        drive_item(7);
        stall = 1'b1;
        flush = 1'b1;
        edge_step();
        stall = 1'b0;
        flush = 1'b0;
        chk("t3_sf_valid", 128'(b_valid), 128'h0);
        chk("t3_sf_ctrl",  128'(b_ctrl),  128'h0);
        chk("t3_sf_data",  128'(b_data),  128'h0);
        for (int i = 7; i <= 9; i++) begin
            drive_item(i);
            edge_step();
            chk($sformatf("t3_refill_valid_%0d", i), 128'(b_valid), 128'(i == 9));
        end
        chk("t3_refill_data", 128'(b_data), 128'(item_data(7)));

        // Bubble with garbage ctrl: ctrl dropped, data still carried
        bub_dat  = item_data(77);
        in_valid = 1'b0;
        in_ctrl  = 12'hFFF;
        in_data  = bub_dat;
        edge_step();
        chk("t4_valid_d1", 128'(a_valid), 128'h0);
        chk("t4_ctrl_d1",  128'(a_ctrl),  128'h0);
        chk("t4_data_d1",  128'(a_data),  128'(bub_dat));
        edge_step();
        edge_step();
        chk("t4_valid_d3", 128'(b_valid), 128'h0);
        chk("t4_ctrl_d3",  128'(b_ctrl),  128'h0);
        chk("t4_data_d3",  128'(b_data),  128'(bub_dat));

        // Bubble counter saturation and clear
        cnt_clr = 1'b1;
        edge_step();
        cnt_clr = 1'b0;
        chk("t5_clr_d3", 128'(b_cnt), 128'h0);
        chk("t5_clr_d1", 128'(a_cnt), 128'h0);
        for (int n = 1; n <= 20; n++) begin
            edge_step();
            exp_cnt = (n > 15) ? 15 : n;
            chk($sformatf("t5_cnt_%0d", n), 128'(b_cnt), 128'(exp_cnt));
        end
        chk("t5_cnt_d1", 128'(a_cnt), 128'd20);
        cnt_clr = 1'b1;
        edge_step();
        cnt_clr = 1'b0;
        chk("t5_reclr", 128'(b_cnt), 128'h0);
        edge_step();
        chk("t5_inc", 128'(b_cnt), 128'h1);

        // Async reset mid-stall with a full pipe
        for (int i = 10; i <= 12; i++) begin
            drive_item(i);
            edge_step();
        end
        chk("t6_full_d3", 128'(b_ctrl), 128'(item_ctrl(10)));
        chk("t6_full_d1", 128'(a_ctrl), 128'(item_ctrl(12)));
        stall = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid_d3", 128'(b_valid), 128'h0);
        chk("t6_rst_ctrl_d3",  128'(b_ctrl),  128'h0);
        chk("t6_rst_data_d3",  128'(b_data),  128'h0);
        chk("t6_rst_cnt_d3",   128'(b_cnt),   128'h0);
        chk("t6_rst_valid_d1", 128'(a_valid), 128'h0);
        chk("t6_rst_cnt_d1",   128'(a_cnt),   128'h0);
        #2;
        reset = 1'b0;
        stall = 1'b0;
        drive_item(13);
        edge_step();
        chk("t6_post_valid_d1", 128'(a_valid), 128'h1);
        chk("t6_post_ctrl_d1",  128'(a_ctrl),  128'(item_ctrl(13)));
        chk("t6_post_valid_d3", 128'(b_valid), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
